// File: rtl/riscv_pkg.sv
// Architectural constants shared across the core and subsystem.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_pkg;
  localparam int PADDR_W = 56;
endpackage

// File: rtl/scariv_lsu_pkg.sv
// L2 command encodings and the request record carried by the L2 buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scariv_lsu_pkg;
  localparam int L2_CMD_TAG_W = 8;
  localparam int L2_DATA_W    = 512;

  localparam logic [1:0] CMD_RD = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;

  typedef struct packed {
    logic [1:0]                 cmd;
    logic [riscv_pkg::PADDR_W-1:0] addr;
    logic [L2_CMD_TAG_W-1:0]    tag;
    logic [L2_DATA_W-1:0]       data;
    logic [L2_DATA_W/8-1:0]     byte_en;
  } l2_buf_req_t;
endpackage

// File: rtl/scariv_ss_sync_fifo.sv
// Generic synchronous FIFO; head is shown combinationally from storage.
// Latency: a push into an empty FIFO is visible at the head the next cycle.
// Backpressure: caller checks o_count_o; pushes while full / pops while empty are ignored.
// Ports: clk/reset, push strobe + data, pop strobe, head data, occupancy count.
module scariv_ss_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  assign head_dat_o = mem_q[rd_ptr_q[PW-1:0]];
  assign count_o    = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is observable until a pointer moves past it.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
    end
  end
endmodule

// File: rtl/scariv_ss_l2_buffer.sv
// Decouples subsystem L2 requests from memory: in-order request queue, read credits, response queue.
// Latency: upstream->memory 1 cycle min (registered queue), memory->upstream response 1 cycle.
// Backpressure: o_req_ready = !req_full; reads stall at head when all credits are used; responses never stall memory.
// Ports: upstream request (i_req_*/o_req_ready), upstream response (o_resp_*/i_resp_ready),
//        memory request (o_mem_req_*/i_mem_req_ready), memory response (i_mem_resp_*/o_mem_resp_ready),
//        status (o_outstanding, o_err_unexp_resp).
module scariv_ss_l2_buffer
  import scariv_lsu_pkg::*;
#(
  parameter int DATA_W          = 512,
  parameter int ADDR_W          = riscv_pkg::PADDR_W,
  parameter int TAG_W           = scariv_lsu_pkg::L2_CMD_TAG_W,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic                                i_req_valid,
  input  logic [1:0]                          i_req_cmd,
  input  logic [ADDR_W-1:0]                   i_req_addr,
  input  logic [TAG_W-1:0]                    i_req_tag,
  input  logic [DATA_W-1:0]                   i_req_data,
  input  logic [DATA_W/8-1:0]                 i_req_byte_en,
  output logic                                o_req_ready,
  output logic                                o_resp_valid,
  output logic [TAG_W-1:0]                    o_resp_tag,
  output logic [DATA_W-1:0]                   o_resp_data,
  input  logic                                i_resp_ready,
  output logic                                o_mem_req_valid,
  output logic [1:0]                          o_mem_req_cmd,
  output logic [ADDR_W-1:0]                   o_mem_req_addr,
  output logic [TAG_W-1:0]                    o_mem_req_tag,
  output logic [DATA_W-1:0]                   o_mem_req_data,
  output logic [DATA_W/8-1:0]                 o_mem_req_byte_en,
  input  logic                                i_mem_req_ready,
  input  logic                                i_mem_resp_valid,
  input  logic [TAG_W-1:0]                    i_mem_resp_tag,
  input  logic [DATA_W-1:0]                   i_mem_resp_data,
  output logic                                o_mem_resp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]    o_outstanding,
  output logic                                o_err_unexp_resp
);
  localparam int BE_W      = DATA_W / 8;
  localparam int REQ_W     = 2 + ADDR_W + TAG_W + DATA_W + BE_W;
  localparam int RESP_W    = TAG_W + DATA_W;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int REQ_CNT_W = $clog2(REQ_DEPTH) + 1;

  logic [REQ_W-1:0]     req_head;
  logic [REQ_CNT_W-1:0] req_cnt;
  logic [RESP_W-1:0]    resp_head;
  logic [CNT_W-1:0]     resp_cnt;
  logic                 req_push, req_empty, head_is_rd, mem_req_hs;
  logic                 up_resp_hs, mem_resp_hs, resp_expected, resp_push;
  logic [CNT_W-1:0]     credits_q, credits_d;
  logic                 err_q, err_d;

  // ---------------- request path ----------------
  assign o_req_ready = (req_cnt != REQ_CNT_W'(REQ_DEPTH));
  assign req_push    = i_req_valid && o_req_ready;
  assign req_empty   = (req_cnt == '0);

  scariv_ss_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i      (i_clk),
    .reset_n_i  (i_reset_n),
    .push_i     (req_push),
    .push_dat_i ({i_req_cmd, i_req_addr, i_req_tag, i_req_data, i_req_byte_en}),
    .pop_i      (mem_req_hs),
    .head_dat_o (req_head),
    .count_o    (req_cnt)
  );

  assign {o_mem_req_cmd, o_mem_req_addr, o_mem_req_tag, o_mem_req_data, o_mem_req_byte_en} = req_head;

  // Strictly in order: a credit-starved read at the head also blocks writes behind it.
  assign head_is_rd      = (o_mem_req_cmd == CMD_RD);
  assign o_mem_req_valid = !req_empty && (!head_is_rd || (credits_q < CNT_W'(MAX_OUTSTANDING)));
  assign mem_req_hs      = o_mem_req_valid && i_mem_req_ready;

  // ---------------- response path ----------------
  assign o_mem_resp_ready = (resp_cnt != CNT_W'(MAX_OUTSTANDING));
  assign mem_resp_hs      = i_mem_resp_valid && o_mem_resp_ready;
  // Credits still held but with no queued response are the reads memory still owes us.
  assign resp_expected    = (credits_q != resp_cnt);
  assign resp_push        = mem_resp_hs && resp_expected;

  scariv_ss_sync_fifo #(.WIDTH(RESP_W), .DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
    .clk_i      (i_clk),
    .reset_n_i  (i_reset_n),
    .push_i     (resp_push),
    .push_dat_i ({i_mem_resp_tag, i_mem_resp_data}),
    .pop_i      (up_resp_hs),
    .head_dat_o (resp_head),
    .count_o    (resp_cnt)
  );

  assign o_resp_valid              = (resp_cnt != '0);
  assign {o_resp_tag, o_resp_data} = resp_head;
  assign up_resp_hs                = o_resp_valid && i_resp_ready;

  // ---------------- credits and error flag ----------------
  // A credit is held until the upstream consumer takes the data, which is what
  // guarantees the response queue always has room for every issued read.
  always_comb begin
    credits_d = credits_q;
    if (mem_req_hs && head_is_rd && !up_resp_hs) begin
      credits_d = credits_q + CNT_W'(1);
    end else if (up_resp_hs && !(mem_req_hs && head_is_rd)) begin
      credits_d = credits_q - CNT_W'(1);
    end
  end

  assign err_d = err_q || (mem_resp_hs && !resp_expected);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign o_outstanding    = credits_q;
  assign o_err_unexp_resp = err_q;
endmodule

// File: tb/tb_scariv_ss_l2_buffer.sv
// Scoreboard bench for the L2 buffer: directed stimulus pushes expectations, monitors pop and compare.
// Latency: n/a.
// Backpressure: bench drives memory/upstream ready directly per scenario.
module tb_scariv_ss_l2_buffer;
  import scariv_lsu_pkg::*;

  localparam int DATA_W = L2_DATA_W;
  localparam int ADDR_W = riscv_pkg::PADDR_W;
  localparam int TAG_W  = L2_CMD_TAG_W;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic              i_clk, i_reset_n;
  logic              i_req_valid;
  logic [1:0]        i_req_cmd;
  logic [ADDR_W-1:0] i_req_addr;
  logic [TAG_W-1:0]  i_req_tag;
  logic [DATA_W-1:0] i_req_data;
  logic [BE_W-1:0]   i_req_byte_en;
  logic              o_req_ready;
  logic              o_resp_valid;
  logic [TAG_W-1:0]  o_resp_tag;
  logic [DATA_W-1:0] o_resp_data;
  logic              i_resp_ready;
  logic              o_mem_req_valid;
  logic [1:0]        o_mem_req_cmd;
  logic [ADDR_W-1:0] o_mem_req_addr;
  logic [TAG_W-1:0]  o_mem_req_tag;
  logic [DATA_W-1:0] o_mem_req_data;
  logic [BE_W-1:0]   o_mem_req_byte_en;
  logic              i_mem_req_ready;
  logic              i_mem_resp_valid;
  logic [TAG_W-1:0]  i_mem_resp_tag;
  logic [DATA_W-1:0] i_mem_resp_data;
  logic              o_mem_resp_ready;
  logic [3:0]        o_outstanding;
  logic              o_err_unexp_resp;

  int checks   = 0;
  int failures = 0;

  l2_buf_req_t exp_req_q[$];
  resp_t       exp_resp_q[$];
  l2_buf_req_t mon_req;
  resp_t       mon_resp;

  scariv_ss_l2_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .REQ_DEPTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr),
    .i_req_tag(i_req_tag), .i_req_data(i_req_data), .i_req_byte_en(i_req_byte_en),
    .o_req_ready(o_req_ready),
    .o_resp_valid(o_resp_valid), .o_resp_tag(o_resp_tag), .o_resp_data(o_resp_data),
    .i_resp_ready(i_resp_ready),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_cmd(o_mem_req_cmd), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_tag(o_mem_req_tag), .o_mem_req_data(o_mem_req_data), .o_mem_req_byte_en(o_mem_req_byte_en),
    .i_mem_req_ready(i_mem_req_ready),
    .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_tag(i_mem_resp_tag), .i_mem_resp_data(i_mem_resp_data),
    .o_mem_resp_ready(o_mem_resp_ready),
    .o_outstanding(o_outstanding), .o_err_unexp_resp(o_err_unexp_resp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] wdata(input logic [TAG_W-1:0] tag);
    return {16{32'hC0DE_0000 | 32'(tag)}};
  endfunction

  function automatic logic [DATA_W-1:0] rdata(input logic [TAG_W-1:0] tag);
    return {16{32'h5A00_0000 | 32'(tag)}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Memory-side request monitor: a handshake completes at the next posedge.
  always @(negedge i_clk) begin
    if (i_reset_n && o_mem_req_valid && i_mem_req_ready) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        failures++;
        $display("FAIL memreq_extra: got tag=0x%0h, expected no request", o_mem_req_tag);
      end else begin
        mon_req = exp_req_q.pop_front();
        if ({o_mem_req_cmd, o_mem_req_addr, o_mem_req_tag, o_mem_req_data, o_mem_req_byte_en} !== mon_req) begin
          failures++;
          $display("FAIL memreq_payload: got cmd=%0h addr=0x%0h tag=0x%0h d=0x%0h, expected cmd=%0h addr=0x%0h tag=0x%0h d=0x%0h",
                   o_mem_req_cmd, o_mem_req_addr, o_mem_req_tag, o_mem_req_data[31:0],
                   mon_req.cmd, mon_req.addr, mon_req.tag, mon_req.data[31:0]);
        end
      end
    end
  end

  // Upstream response monitor.
  always @(negedge i_clk) begin
    if (i_reset_n && o_resp_valid && i_resp_ready) begin
      checks++;
      if (exp_resp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_extra: got tag=0x%0h, expected no response", o_resp_tag);
      end else begin
        mon_resp = exp_resp_q.pop_front();
        if ({o_resp_tag, o_resp_data} !== mon_resp) begin
          failures++;
          $display("FAIL resp_payload: got tag=0x%0h d=0x%0h, expected tag=0x%0h d=0x%0h",
                   o_resp_tag, o_resp_data[31:0], mon_resp.tag, mon_resp.data[31:0]);
        end
      end
    end
  end

  task automatic push_req(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag);
    l2_buf_req_t r;
    int n;
    r.cmd     = cmd;
    r.addr    = addr;
    r.tag     = tag;
    r.data    = wdata(tag);
    r.byte_en = (cmd == CMD_RD) ? '0 : '1;
    i_req_valid   = 1'b1;
    i_req_cmd     = r.cmd;
    i_req_addr    = r.addr;
    i_req_tag     = r.tag;
    i_req_data    = r.data;
    i_req_byte_en = r.byte_en;
    n = 0;
    while (!o_req_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n == 50) begin
      failures++;
      $display("FAIL req_accept_timeout: tag=0x%0h got o_req_ready=0 for 50 cycles, expected 1", tag);
    end else begin
      exp_req_q.push_back(r);
      step();
    end
    i_req_valid = 1'b0;
  endtask

  task automatic mem_resp(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data, input bit expect_fwd);
    resp_t e;
    e.tag  = tag;
    e.data = data;
    if (expect_fwd) exp_resp_q.push_back(e);
    i_mem_resp_valid = 1'b1;
    i_mem_resp_tag   = tag;
    i_mem_resp_data  = data;
    step();
    i_mem_resp_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"},      64'(o_req_ready), 1);
    chk({pfx, "_mem_req_valid"},  64'(o_mem_req_valid), 0);
    chk({pfx, "_resp_valid"},     64'(o_resp_valid), 0);
    chk({pfx, "_mem_resp_ready"}, 64'(o_mem_resp_ready), 1);
    chk({pfx, "_outstanding"},    64'(o_outstanding), 0);
    chk({pfx, "_err"},            64'(o_err_unexp_resp), 0);
  endtask

  initial begin
    i_reset_n = 1'b0; i_req_valid = 1'b0; i_req_cmd = '0; i_req_addr = '0; i_req_tag = '0;
    i_req_data = '0; i_req_byte_en = '0; i_resp_ready = 1'b0; i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b0; i_mem_resp_tag = '0; i_mem_resp_data = '0;
    repeat (3) step();
    chk_reset_vals("rst");
    i_reset_n = 1'b1;
    step();

    // Single read
    i_mem_req_ready = 1'b1;
    i_resp_ready    = 1'b1;
    push_req(CMD_RD, 'h8000_0000, 8'd3);
    chk("t1_memreq_vld", 64'(o_mem_req_valid), 1);
    chk("t1_outst_pre", 64'(o_outstanding), 0);
    step();
    chk("t1_outst_issued", 64'(o_outstanding), 1);
    mem_resp(8'd3, {64{8'hA5}}, 1'b1);
    chk("t1_resp_vld", 64'(o_resp_valid), 1);
    step();
    chk("t1_outst_done", 64'(o_outstanding), 0);
    chk("t1_resp_vld_done", 64'(o_resp_valid), 0);

    // Credit limit and head-of-line: 9 reads then a write, no upstream acceptance
    i_resp_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_req(CMD_RD, ADDR_W'('h1000 + i * 64), TAG_W'(16 + i));
    push_req(CMD_WR, 'h2000, 8'd40);
    repeat (3) step();
    chk("t2_outst_full", 64'(o_outstanding), 8);
    chk("t2_head_blocked", 64'(o_mem_req_valid), 0);
    chk("t2_unissued", 64'(exp_req_q.size()), 2);
    chk("t2_head_tag", 64'(o_mem_req_tag), 24);
    mem_resp(8'd16, rdata(8'd16), 1'b1);
    i_resp_ready = 1'b1;
    step();
    i_resp_ready = 1'b0;
    chk("t2_outst_released", 64'(o_outstanding), 7);
    chk("t2_ninth_vld", 64'(o_mem_req_valid), 1);
    step();
    chk("t2_outst_refull", 64'(o_outstanding), 8);
    chk("t3_wr_head_tag", 64'(o_mem_req_tag), 40);
    step();
    chk("t3_all_issued", 64'(exp_req_q.size()), 0);
    i_resp_ready = 1'b1;
    for (int i = 1; i < 9; i++) mem_resp(TAG_W'(16 + i), rdata(TAG_W'(16 + i)), 1'b1);
    repeat (3) step();
    chk("t2_outst_drained", 64'(o_outstanding), 0);

    // Backpressure: memory stalled, fill the request queue
    i_mem_req_ready = 1'b0;
    push_req(CMD_WR, 'h3000, 8'd50);
    push_req(CMD_WR, 'h3040, 8'd51);
    push_req(CMD_RD, 'h3080, 8'd52);
    push_req(CMD_WR, 'h30C0, 8'd53);
    chk("t4_req_ready_full", 64'(o_req_ready), 0);
    for (int k = 0; k < 3; k++) begin
      chk("t4_stable_tag", 64'(o_mem_req_tag), 50);
      chk("t4_stable_addr", 64'(o_mem_req_addr), 'h3000);
      step();
    end
    i_mem_req_ready = 1'b1;
    chk("t4_ready_same_cycle", 64'(o_req_ready), 0);
    step();
    chk("t4_ready_next_cycle", 64'(o_req_ready), 1);
    repeat (3) step();
    chk("t4_drained", 64'(exp_req_q.size()), 0);
    chk("t4_memreq_idle", 64'(o_mem_req_valid), 0);
    mem_resp(8'd52, rdata(8'd52), 1'b1);
    repeat (2) step();
    chk("t4_outst", 64'(o_outstanding), 0);

    // Simultaneous credit increment and decrement
    i_resp_ready = 1'b0;
    push_req(CMD_RD, 'h4000, 8'd60);
    step();
    mem_resp(8'd60, rdata(8'd60), 1'b1);
    i_mem_req_ready = 1'b0;
    push_req(CMD_RD, 'h4040, 8'd61);
    chk("t5_outst_before", 64'(o_outstanding), 1);
    chk("t5_memreq_vld", 64'(o_mem_req_valid), 1);
    chk("t5_resp_vld", 64'(o_resp_valid), 1);
    i_mem_req_ready = 1'b1;
    i_resp_ready    = 1'b1;
    step();
    chk("t5_outst_same", 64'(o_outstanding), 1);
    mem_resp(8'd61, rdata(8'd61), 1'b1);
    repeat (2) step();
    chk("t5_outst_done", 64'(o_outstanding), 0);

    // Unexpected response, sticky error, then reset with queues part-full
    chk("t6_err_clear", 64'(o_err_unexp_resp), 0);
    mem_resp(8'd70, rdata(8'd70), 1'b0);
    chk("t6_err_set", 64'(o_err_unexp_resp), 1);
    chk("t6_dropped", 64'(o_resp_valid), 0);
    repeat (3) step();
    chk("t6_err_sticky", 64'(o_err_unexp_resp), 1);
    i_resp_ready = 1'b0;
    push_req(CMD_RD, 'h5000, 8'd80);
    step();
    mem_resp(8'd80, rdata(8'd80), 1'b1);
    i_mem_req_ready = 1'b0;
    push_req(CMD_WR, 'h5040, 8'd81);
    push_req(CMD_RD, 'h5080, 8'd82);
    chk("t6_resp_pending", 64'(o_resp_valid), 1);
    i_reset_n = 1'b0;
    step();
    exp_req_q.delete();
    exp_resp_q.delete();
    chk_reset_vals("t6_rst");
    i_reset_n = 1'b1;
    step();

    // Normal operation after reset
    i_mem_req_ready = 1'b1;
    i_resp_ready    = 1'b1;
    push_req(CMD_RD, 'h6000, 8'd90);
    step();
    chk("t7_outst", 64'(o_outstanding), 1);
    mem_resp(8'd90, rdata(8'd90), 1'b1);
    repeat (2) step();
    chk("t7_outst_done", 64'(o_outstanding), 0);
    chk("end_req_q_empty", 64'(exp_req_q.size()), 0);
    chk("end_resp_q_empty", 64'(exp_resp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
